// File: rtl/chip8_pkg.sv
// Shared definitions for the CHIP-8 memory block: loader state encoding,
// boot jump opcode and the built-in hexadecimal font table.
package chip8_pkg;

    localparam int ADDR_W     = 12;
    localparam int FONT_BYTES = 80;

    localparam logic [3:0] JUMP_OPCODE = 4'h1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_LOAD  = 2'd2,
        ST_RUN   = 2'd3
    } state_t;

    // Glyphs for digits 0-F, five rows each, top row first.
    localparam logic [7:0] FONT_TABLE [FONT_BYTES] = '{
        8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,
        8'h20, 8'h60, 8'h20, 8'h20, 8'h70,
        8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,
        8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,
        8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,
        8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,
        8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,
        8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,
        8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,
        8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,
        8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,
        8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,
        8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,
        8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,
        8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,
        8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80
    };

endpackage

// File: rtl/chip8_font_rom.sv
// Combinational hex font lookup.
// index_i: byte offset into the font (0..79); data_o: font byte, 0 past the end.
module chip8_font_rom
    import chip8_pkg::*;
(
    input  logic [6:0] index_i,
    output logic [7:0] data_o
);

    always_comb begin
        data_o = 8'h00;
        if (index_i < 7'(FONT_BYTES)) begin
            data_o = FONT_TABLE[index_i];
        end
    end

endmodule

// File: rtl/chip8_memory.sv
// CHIP-8 4 KiB byte memory with built-in program loader and core reset control.
// Ports: clock/reset (async active-low); cpu_* core RAM port and core reset;
// load_* byte-stream loader handshake; busy/load_error/load_count status.
module chip8_memory
    import chip8_pkg::*;
#(
    parameter int          MEM_SIZE  = 4096,
    parameter logic [11:0] LOAD_BASE = 12'h200,
    parameter logic [11:0] FONT_BASE = 12'h050
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] cpu_address_in,
    input  logic [7:0]  cpu_data_in,
    input  logic        cpu_write_in,
    output logic [7:0]  cpu_data_out,
    output logic        cpu_reset_n_out,
    input  logic        load_start,
    input  logic        load_valid,
    input  logic [7:0]  load_data,
    input  logic        load_last,
    output logic        load_ready,
    output logic        busy,
    output logic        load_error,
    output logic [12:0] load_count
);

    localparam logic [11:0] LAST_ADDR = 12'(MEM_SIZE - 1);
    localparam logic [11:0] FONT_END  = FONT_BASE + 12'(FONT_BYTES);

    logic [7:0]  mem_q [MEM_SIZE];

    state_t      state_q, state_d;
    logic [11:0] ptr_q, ptr_d;
    logic [12:0] count_q, count_d;
    logic        err_q, err_d;
    logic        rdy_q, rdy_d;
    logic        core_rst_n_q, core_rst_n_d;
    logic [7:0]  rdata_q, rdata_d;

    logic        wr_en;
    logic [11:0] wr_addr;
    logic [7:0]  wr_data;
    logic [7:0]  clear_byte;
    logic [7:0]  font_byte;
    logic [6:0]  font_idx;
    logic        at_end;

    assign font_idx = 7'(ptr_q - FONT_BASE);
    assign at_end   = (ptr_q == LAST_ADDR);

    chip8_font_rom u_font (
        .index_i (font_idx),
        .data_o  (font_byte)
    );

    // Boot image: jump to LOAD_BASE at 0x000, font at FONT_BASE, zero elsewhere.
    always_comb begin
        clear_byte = 8'h00;
        if (ptr_q == 12'h000) begin
            clear_byte = {JUMP_OPCODE, LOAD_BASE[11:8]};
        end else if (ptr_q == 12'h001) begin
            clear_byte = LOAD_BASE[7:0];
        end else if (ptr_q >= FONT_BASE && ptr_q < FONT_END) begin
            clear_byte = font_byte;
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        count_d      = count_q;
        err_d        = err_q;
        rdy_d        = rdy_q;
        core_rst_n_d = core_rst_n_q;
        wr_en        = 1'b0;
        wr_addr      = cpu_address_in;
        wr_data      = cpu_data_in;
        rdata_d      = 8'h00;

        unique case (state_q)
            ST_IDLE: begin
            end
            ST_CLEAR: begin
                wr_en   = 1'b1;
                wr_addr = ptr_q;
                wr_data = clear_byte;
                if (at_end) begin
                    state_d = ST_LOAD;
                    ptr_d   = LOAD_BASE;
                    rdy_d   = 1'b1;
                end else begin
                    ptr_d = ptr_q + 12'd1;
                end
            end
            ST_LOAD: begin
                if (load_valid && rdy_q) begin
                    wr_en   = 1'b1;
                    wr_addr = ptr_q;
                    wr_data = load_data;
                    count_d = count_q + 13'd1;
                    // Pointer stops at the top; no wrap into the boot area.
                    if (load_last || at_end) begin
                        state_d      = ST_RUN;
                        rdy_d        = 1'b0;
                        core_rst_n_d = 1'b1;
                        err_d        = at_end && !load_last;
                    end else begin
                        ptr_d = ptr_q + 12'd1;
                    end
                end
            end
            ST_RUN: begin
                wr_en   = cpu_write_in;
                rdata_d = mem_q[cpu_address_in];
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A new load always wins, from any state.
        if (load_start) begin
            state_d      = ST_CLEAR;
            ptr_d        = 12'h000;
            count_d      = 13'd0;
            err_d        = 1'b0;
            rdy_d        = 1'b0;
            core_rst_n_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            ptr_q        <= 12'h000;
            count_q      <= 13'd0;
            err_q        <= 1'b0;
            rdy_q        <= 1'b0;
            core_rst_n_q <= 1'b0;
            rdata_q      <= 8'h00;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            count_q      <= count_d;
            err_q        <= err_d;
            rdy_q        <= rdy_d;
            core_rst_n_q <= core_rst_n_d;
            rdata_q      <= rdata_d;
        end
    end

    // Storage is not reset; the read above sees the pre-write value.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign cpu_data_out    = rdata_q;
    assign cpu_reset_n_out = core_rst_n_q;
    assign load_ready      = rdy_q;
    assign busy            = (state_q == ST_CLEAR) || (state_q == ST_LOAD);
    assign load_error      = err_q;
    assign load_count      = count_q;

endmodule

// File: doc/chip8_memory.md
Name: chip8_memory

Overview:
- Byte-wide 4 KiB memory that responds to the CHIP-8 core's RAM initiator port: address, write data, write strobe in; read data out.
- Also owns program loading. A byte-stream loader port clears memory, installs the hex font and a boot jump, then streams a ROM image into memory.
- Holds the core in reset until loading completes, then hands the memory over to the core.

Parameters:
- MEM_SIZE, 4096, bytes of storage; address width 12.
- LOAD_BASE, 12'h200, address of the first loaded ROM byte.
- FONT_BASE, 12'h050, address of the first of 80 font bytes.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low
- cpu_address_in  in  12  core byte address
- cpu_data_in  in  8  core write data
- cpu_write_in  in  1  core write strobe, level-sensitive
- cpu_data_out  out  8  registered read data
- cpu_reset_n_out  out  1  active-low reset to the core
- load_start  in  1  pulse; begins clear and load
- load_valid  in  1  loader byte valid
- load_data  in  8  loader byte
- load_last  in  1  qualifies the final byte
- load_ready  out  1  memory accepts loader bytes
- busy  out  1  high in CLEAR or LOAD
- load_error  out  1  image overflowed memory
- load_count  out  13  bytes accepted in the last load

Behaviour:
- Reset values:
  - state = IDLE
  - cpu_reset_n_out = 0
  - cpu_data_out = 0
  - load_ready = 0
  - busy = 0
  - load_error = 0
  - load_count = 0
  - Memory contents are not reset.
- States: IDLE, CLEAR, LOAD, RUN.
- IDLE:
  - Core held in reset; CPU port ignored.
  - load_start moves to CLEAR on the next edge: clear pointer = 0, load_error = 0, load_count = 0.
- CLEAR: one write per cycle to addresses 0..MEM_SIZE-1, MEM_SIZE cycles total. Value written:
  - at 0x000: {4'h1, LOAD_BASE[11:8]}
  - at 0x001: LOAD_BASE[7:0]
  - at FONT_BASE..FONT_BASE+79: font table byte (address - FONT_BASE)
  - everywhere else: 8'h00
- CLEAR to LOAD: after address MEM_SIZE-1 is written, move to LOAD. Load pointer = LOAD_BASE.
- LOAD acceptance:
  - load_ready = 1 registered for the whole state.
  - A byte transfers on an edge with load_valid && load_ready.
  - Each transfer writes mem[pointer] = load_data, increments the pointer and increments load_count.
- LOAD exit:
  - A transfer with load_last = 1, or a transfer to address MEM_SIZE-1, moves to RUN.
  - A transfer to MEM_SIZE-1 without load_last sets load_error = 1.
  - The pointer never wraps.
  - load_ready falls on the same edge.
- RUN:
  - cpu_reset_n_out = 1, set on the edge that enters RUN.
  - CPU port active; loader ignored.
  - load_start in RUN goes to CLEAR and drives cpu_reset_n_out = 0 on that edge.
- CPU read:
  - cpu_data_out <= mem[cpu_address_in] every edge in RUN; latency is 1 cycle from the address.
  - Outside RUN, cpu_data_out = 0.
- CPU write:
  - mem[cpu_address_in] <= cpu_data_in on each edge with cpu_write_in = 1 in RUN.
  - Repeated edges rewrite the same value, which is harmless.
  - CPU writes outside RUN are dropped.
- Same-address read and write on one edge: cpu_data_out returns the old data (read-before-write).
- load_start during CLEAR or LOAD restarts CLEAR from address 0; the partial load is discarded.
- load_valid in IDLE, CLEAR or RUN is ignored and no byte is consumed.
- Asynchronous reset mid-operation returns to IDLE with all outputs at reset values. Memory may be partially written.
- Single write port: the write mux selects from clear, load or CPU by state, so writes never collide.

Decomposition:
- Package chip8_pkg holds:
  - state encoding constants
  - FONT_BYTES = 80
  - the 80-byte hex font table (digits 0-F, 5 bytes each, e.g. digit 0 = F0 90 90 90 F0)
  - JUMP_OPCODE = 4'h1
- Sub-module chip8_font_rom: combinational 7-bit index to 8-bit font byte.

Test Plan:
- Reset, pulse load_start, send bytes 60 2A, 70 01 with load_last on 01 -> CLEAR lasts 4096 cycles. Afterwards:
  - mem[000..001] = 12 00
  - mem[050..054] = F0 90 90 90 F0
  - mem[200..203] = 60 2A 70 01
  - load_count = 4, load_error = 0
  - cpu_reset_n_out rises on the edge after the last byte.
- RUN, cpu_address_in = 0x201 -> cpu_data_out = 2A one cycle later.
- RUN, write 0x55 to 0x300 with cpu_write_in held for 3 cycles, then read 0x300 -> 55. Same-edge read of 0x300 during the first write returns 00.
- LOAD_BASE = 0xFFE; send 3 bytes without load_last ->
  - only 2 are accepted
  - load_error = 1, load_count = 2
  - load_ready falls after the second byte.
- Pulse load_start while in LOAD -> restarts CLEAR at address 0 and busy stays 1. In RUN, load_start drops cpu_reset_n_out to 0 on the same edge.
- Assert reset during LOAD -> state returns to IDLE and all outputs are at reset values. A CPU write in IDLE is dropped, and a later load shows the target byte = 00.
